// File: rtl/irq_pending_ctrl.sv
// Eight-line interrupt pending controller: synchronizes async requests, latches
// rising edges as pending events and presents the highest-priority unmasked line.
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       irq_ready,
    input  logic       ovf_clr,
    output logic       irq_valid,
    output logic [2:0] irq_code,
    output logic [7:0] overflow
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] dly_q;
    logic [7:0] pending_q, pending_d;
    logic [7:0] overflow_d;
    logic [7:0] rise, clr, ovf_set, eligible;
    logic       accept;
    logic       valid_d;
    logic [2:0] code_d;

    // Highest set bit wins; the ascending scan lets later (higher) bits overwrite.
    function automatic logic [2:0] highest(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // The whole chain resets so a line held high across release yields one edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            dly_q <= '0;
        end else begin
            sync_q[0] <= req;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign accept   = irq_valid & irq_ready;
    assign clr      = accept ? (8'b1 << irq_code) : 8'b0;
    assign eligible = pending_q & ~mask;

    // A new edge on a line being cleared re-arms it rather than counting as lost.
    assign ovf_set    = rise & pending_q & ~clr;
    assign pending_d  = rise | (pending_q & ~clr);
    assign overflow_d = (ovf_clr ? 8'b0 : overflow) | ovf_set;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        valid_d = irq_valid;
        code_d  = irq_code;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    valid_d = 1'b1;
                    code_d  = highest(eligible);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            overflow  <= '0;
            irq_valid <= 1'b0;
            irq_code  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overflow  <= overflow_d;
            irq_valid <= valid_d;
            irq_code  <= code_d;
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl (SYNC_STAGES=2): latency, priority, masking,
// overflow, set-wins on accept and reset behaviour.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ready;
    logic       ovf_clr;
    logic       irq_valid;
    logic [2:0] irq_code;
    logic [7:0] overflow;

    int n_tests = 0;
    int n_fail  = 0;

    irq_pending_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_ready (irq_ready),
        .ovf_clr   (ovf_clr),
        .irq_valid (irq_valid),
        .irq_code  (irq_code),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a presentation, check it, hold for some cycles, then accept.
    task automatic expect_code(input string tag, input logic [2:0] code, input int hold);
        int n = 0;
        while (!irq_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " valid"}, {7'b0, irq_valid}, 8'd1);
        check({tag, " code"}, {5'b0, irq_code}, {5'b0, code});
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold valid"}, {7'b0, irq_valid}, 8'd1);
            check({tag, " hold code"}, {5'b0, irq_code}, {5'b0, code});
        end
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check({tag, " drop"}, {7'b0, irq_valid}, 8'd0);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, {7'b0, irq_valid}, 8'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 8'hFF;
        mask      = 8'h00;
        irq_ready = 1'b0;
        ovf_clr   = 1'b0;

        // Reset held with every request high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst valid", {7'b0, irq_valid}, 8'd0);
            check("rst code", {5'b0, irq_code}, 8'd0);
            check("rst ovf", overflow, 8'h00);
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("post-rst lat valid", {7'b0, irq_valid}, 8'd0);
        tick();
        check("post-rst first valid", {7'b0, irq_valid}, 8'd1);
        check("post-rst first code", {5'b0, irq_code}, 8'd7);
        req = 8'h00;
        expect_code("post-rst c7", 3'd7, 0);
        for (int c = 6; c >= 0; c--) expect_code("post-rst drain", c[2:0], 0);
        expect_idle("post-rst single edge", 6);
        check("post-rst ovf", overflow, 8'h00);

        // Single pulse on line 3, consumer always ready
        irq_ready = 1'b1;
        req = 8'h08;
        tick();
        req = 8'h00;
        tick(); tick();
        check("lat e2 valid", {7'b0, irq_valid}, 8'd0);
        tick();
        check("lat e3 valid", {7'b0, irq_valid}, 8'd1);
        check("lat e3 code", {5'b0, irq_code}, 8'd3);
        tick();
        check("lat e4 drop", {7'b0, irq_valid}, 8'd0);
        expect_idle("lat no more", 6);
        irq_ready = 1'b0;

        // Priority order with the consumer stalling five cycles per code
        req = 8'b1001_0011;
        tick();
        req = 8'h00;
        expect_code("prio c7", 3'd7, 5);
        expect_code("prio c4", 3'd4, 5);
        expect_code("prio c1", 3'd1, 5);
        expect_code("prio c0", 3'd0, 5);
        expect_idle("prio done", 4);
        check("prio ovf", overflow, 8'h00);

        // Masked line stays pending until unmasked
        mask = 8'h80;
        req  = 8'b1001_0000;
        tick();
        req = 8'h00;
        expect_code("mask c4", 3'd4, 0);
        expect_idle("mask blocks 7", 4);
        mask = 8'h00;
        expect_code("unmask c7", 3'd7, 0);

        // Two edges on line 5 while pending -> overflow, then clear
        req = 8'h20; tick();
        req = 8'h00; tick();
        req = 8'h20; tick();
        req = 8'h00;
        tick(); tick(); tick();
        check("ovf set", overflow, 8'h20);
        check("ovf still pending", {7'b0, irq_valid}, 8'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf clr", overflow, 8'h00);
        expect_code("ovf c5", 3'd5, 0);
        expect_idle("ovf one event", 4);

        // New edge on line 2 lands in the same cycle as the accept of code 2
        req = 8'h04; tick();
        req = 8'h00;
        begin
            int n = 0;
            while (!irq_valid && n < 20) begin tick(); n++; end
        end
        check("setwin first valid", {7'b0, irq_valid}, 8'd1);
        check("setwin first code", {5'b0, irq_code}, 8'd2);
        req = 8'h04; tick();
        req = 8'h00; tick();
        irq_ready = 1'b1;
        tick();
        irq_ready = 1'b0;
        check("setwin drop", {7'b0, irq_valid}, 8'd0);
        check("setwin ovf", overflow, 8'h00);
        expect_code("setwin second c2", 3'd2, 0);
        check("setwin ovf after", overflow, 8'h00);
        expect_idle("setwin done", 4);

        // Reset during a handshake discards the event
        req = 8'h40; tick();
        req = 8'h00;
        begin
            int n = 0;
            while (!irq_valid && n < 20) begin tick(); n++; end
        end
        check("midrst valid", {7'b0, irq_valid}, 8'd1);
        irq_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        irq_ready = 1'b0;
        check("midrst valid cleared", {7'b0, irq_valid}, 8'd0);
        check("midrst code cleared", {5'b0, irq_code}, 8'd0);
        rst_n = 1'b1;
        expect_idle("midrst discarded", 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter: SYNC_STAGES, default 2, input synchronizer depth; legal values are 1 to 3.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: req  input  8  asynchronous request lines; bit 7 has highest priority.
REQ-006 Port: mask  input  8  per-line mask; 1 = line masked, synchronous to clk.
REQ-007 Port: irq_ready  input  1  consumer accepts the presented code.
REQ-008 Port: ovf_clr  input  1  clears all overflow bits.
REQ-009 Port: irq_valid  output  1  registered; irq_code is valid.
REQ-010 Port: irq_code  output  3  registered; index of the presented line.
REQ-011 Port: overflow  output  8  registered; sticky lost-event flags.

Function
REQ-012 Each req bit SHALL pass through a SYNC_STAGES flop chain, followed by a delay flop used for rising-edge detection.
REQ-013 A rising edge on a synchronized line SHALL set pending[i] on the next clk edge.
- With SYNC_STAGES=2, req rising before edge 0 sets pending at edge 2.
REQ-014 The FSM SHALL have two states, IDLE and PRESENT.
REQ-015 In IDLE, when (pending & ~mask) != 0, the block SHALL register irq_code = index of the highest set bit, register irq_valid=1, and go to PRESENT.
REQ-016 In PRESENT, irq_code and irq_valid SHALL hold stable until irq_ready=1, regardless of mask or pending changes.
REQ-017 On irq_valid & irq_ready, the block SHALL clear pending[irq_code], drive irq_valid=0 on the next edge, and return to IDLE.
- Minimum one-cycle bubble between consecutive irq_valid pulses.
REQ-018 End-to-end latency SHALL be fixed: with SYNC_STAGES=S and the FSM idle, req rising before edge 0 gives irq_valid=1 after edge S+1.
REQ-019 An edge on line i coinciding with the clearing of pending[i] SHALL leave pending[i]=1 (set wins) and SHALL NOT set overflow[i].
REQ-020 An edge on line i while pending[i]=1 and pending[i] is not being cleared SHALL set overflow[i].
- The event is lost; pending[i] stays 1.
REQ-021 ovf_clr=1 SHALL clear overflow to 0 on the next edge; an overflow set in the same cycle wins for that bit.
REQ-022 Masked lines SHALL still capture pending and overflow; masking only blocks selection in IDLE.
REQ-023 irq_ready while irq_valid=0 SHALL have no effect.

Reset
REQ-024 rst_n=0 at a clk edge SHALL clear to 0 all of the following: sync chain, edge-delay flop, pending, overflow, irq_valid, irq_code.
- The FSM enters IDLE.
REQ-025 Reset asserted mid-handshake SHALL discard all pending events; no accept is recorded.
REQ-026 A req line held high across reset release SHALL register exactly one rising edge after release, because the sync chain resets to 0.

Verification (SYNC_STAGES=2)
REQ-027 Reset with req=8'hFF held for 3 cycles -> irq_valid=0, irq_code=0, overflow=0 during reset; after release, irq_code=7 is presented first.
REQ-028 Pulse on req[3], mask=0, irq_ready=1 -> irq_valid=1 after edge 3 with irq_code=3; irq_valid falls the next cycle; no further irq.
REQ-029 req=8'b10010011 in a single pulse, with irq_ready=0 for 5 cycles per code -> codes 7, 4, 1, 0 in that order; irq_code is stable while waiting.
REQ-030 mask=8'h80 with req=8'b10010000 -> only code 4 is presented; then mask=0 -> code 7 is presented.
REQ-031 Two rising edges on req[5] with irq_ready=0 -> overflow=8'h20; ovf_clr pulse -> overflow=8'h00 on the next edge.
REQ-032 A new req[2] edge reaching pending in the same cycle as the accept of code 2 -> a second irq with code 2 follows; overflow[2]=0.
